// File: rtl/mul_pipe_pkg.sv
// Shared defaults and helpers for the mul_pipe_ns multiplier and its bus interface.
// The pipeline slice type is width-dependent, so it is provided as a macro taking the product width.
package mul_pipe_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_TRUNC  = 4;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

`define MUL_PIPE_STAGE_T(PW) struct packed { logic vld; logic sgn; logic [(PW)-1:0] prod; }

// File: rtl/mul_pipe_ns_if.sv
// Operand/product handshake bundle for mul_pipe_ns; the slave side is the multiplier.
interface mul_pipe_ns_if
  import mul_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   O;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  modport master (
    output in_valid, in_signed, A, B, out_ready,
    input  in_ready, out_valid, O, op_count, busy
  );

  modport slave (
    input  in_valid, in_signed, A, B, out_ready,
    output in_ready, out_valid, O, op_count, busy
  );

endinterface

// File: rtl/mul_pipe_stage.sv
// One enable-gated register slice of the multiplier pipeline; the payload type is a parameter.
module mul_pipe_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  T     d_i,
  output T     q_o
);

  T slice_q;

  // NOTE: non-blocking assignment so every slice samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slice_q <= '0;
    end else if (en_i) begin
      slice_q <= d_i;
    end
  end

  assign q_o = slice_q;

endmodule

// File: rtl/mul_pipe_ns.sv
// Pipelined W x W multiplier with per-beat signed/unsigned mode, valid/ready backpressure and op counter.
// Build option MUL_PIPE_APPROX_EN: when defined, the low TRUNC product bits are forced to zero.
module mul_pipe_ns
  import mul_pipe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TRUNC  = DEF_TRUNC
) (
  input  logic         clk,
  input  logic         rst,
  mul_pipe_ns_if.slave bus
);

  localparam int PW = prod_w(W);

`ifdef MUL_PIPE_APPROX_EN
  localparam int TRUNC_EFF = TRUNC;
`else
  localparam int TRUNC_EFF = 0;
`endif

  localparam logic [PW-1:0] KEEP_MASK = ~(PW'((64'd1 << TRUNC_EFF) - 64'd1));

  typedef `MUL_PIPE_STAGE_T(PW) stage_t;

  logic                    en;
  logic [PW-1:0]           a_ext;
  logic [PW-1:0]           b_ext;
  stage_t                  stage_in;
  stage_t [STAGES-1:0]     stage_d;
  stage_t [STAGES-1:0]     stage_q;
  logic                    busy_c;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    unused_sgn;

  // Low PW bits of the extended product are the exact result in either mode.
  always_comb begin
    a_ext         = bus.in_signed ? {{W{bus.A[W-1]}}, bus.A} : {{W{1'b0}}, bus.A};
    b_ext         = bus.in_signed ? {{W{bus.B[W-1]}}, bus.B} : {{W{1'b0}}, bus.B};
    stage_in.vld  = bus.in_valid;
    stage_in.sgn  = bus.in_signed;
    stage_in.prod = (a_ext * b_ext) & KEEP_MASK;
  end

  // The whole pipeline moves as one; a stalled output freezes every slice, bubbles included.
  assign en = !stage_q[STAGES-1].vld | bus.out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign stage_d[i] = stage_in;
    end else begin : g_next
      assign stage_d[i] = stage_q[i-1];
    end

    mul_pipe_stage #(.T(stage_t)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .d_i  (stage_d[i]),
      .q_o  (stage_q[i])
    );
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy_c = busy_c | stage_q[i].vld;
    end
    cnt_d = cnt_q;
    if (stage_q[STAGES-1].vld && bus.out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign unused_sgn    = stage_q[STAGES-1].sgn;
  assign bus.in_ready  = en;
  assign bus.out_valid = stage_q[STAGES-1].vld;
  assign bus.O         = stage_q[STAGES-1].prod;
  assign bus.op_count  = cnt_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_mul_pipe_ns.sv
// Directed bench for mul_pipe_ns (W=8, STAGES=2): latency, modes, streaming, backpressure, reset, counter wrap.
module tb_mul_pipe_ns;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  // Hand-computed exact products.
  vec_t vt [10] = '{
    '{8'd3,   8'd5,   1'b1, 16'h000F},
    '{8'd200, 8'd2,   1'b0, 16'h0190},
    '{8'hFF,  8'd1,   1'b1, 16'hFFFF},
    '{8'd16,  8'd16,  1'b0, 16'h0100},
    '{8'hFE,  8'hFD,  1'b1, 16'h0006},
    '{8'd128, 8'd128, 1'b0, 16'h4000},
    '{8'd100, 8'h9C,  1'b1, 16'hD8F0},
    '{8'd0,   8'd255, 1'b0, 16'h0000},
    '{8'd127, 8'd127, 1'b1, 16'h3F01},
    '{8'd13,  8'd11,  1'b1, 16'h008F}
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          cyc     = 0;
  int          rdy_low = 0;
  logic [15:0] exp_q [$];

  mul_pipe_ns_if #(.W(8), .CNT_W(16)) u_if ();
  mul_pipe_ns_if #(.W(8), .CNT_W(4))  u_if4 ();

  mul_pipe_ns #(.W(8), .STAGES(2), .CNT_W(16), .TRUNC(4)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (u_if.slave)
  );

  mul_pipe_ns #(.W(8), .STAGES(2), .CNT_W(4), .TRUNC(4)) u_dut4 (
    .clk (clk),
    .rst (rst_n),
    .bus (u_if4.slave)
  );

  assign u_if4.in_valid  = u_if.in_valid;
  assign u_if4.in_signed = u_if.in_signed;
  assign u_if4.A         = u_if.A;
  assign u_if4.B         = u_if.B;
  assign u_if4.out_ready = u_if.out_ready;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] apx(input logic [15:0] x);
`ifdef MUL_PIPE_APPROX_EN
    return x & 16'hFFF0;
`else
    return x;
`endif
  endfunction

  // Output handshake will happen at the next rising edge: score it against the queue.
  always @(negedge clk) begin
    if (rst_n && u_if.out_valid && u_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(u_if.O), 32'hDEAD);
      end else begin
        check("product", 32'(u_if.O), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exact);
    int   k;
    logic took;
    u_if.in_valid  = 1'b1;
    u_if.A         = a;
    u_if.B         = b;
    u_if.in_signed = s;
    exp_q.push_back(apx(exact));
    k = 0;
    do begin
      took = u_if.in_ready;
      if (!took) rdy_low++;
      @(posedge clk);
      #1;
      k++;
    end while (!took && k < 20);
    if (!took) check("accept_timeout", 32'(took), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    u_if.in_valid  = 1'b0;
    u_if.in_signed = 1'b0;
    u_if.A         = '0;
    u_if.B         = '0;
    u_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_busy",      32'(u_if.busy),      32'd0);
    check("rst_op_count",  32'(u_if.op_count),  32'd0);
    check("rst_O",         32'(u_if.O),         32'd0);
    check("rst_in_ready",  32'(u_if.in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed corner products and two-cycle latency.
    u_if.out_ready = 1'b1;
    send(8'h80, 8'h80, 1'b1, 16'h4000);
    u_if.in_valid = 1'b0;
    check("t1_lat_early", 32'(u_if.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat_valid", 32'(u_if.out_valid), 32'd1);
    check("t1_O_4000",    32'(u_if.O),         32'(apx(16'h4000)));
    send(8'h7F, 8'h80, 1'b1, 16'hC080);
    u_if.in_valid = 1'b0;
    check("t1b_lat_early", 32'(u_if.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_O_C080", 32'(u_if.O), 32'(apx(16'hC080)));
    drain();
    check("t1_count", 32'(u_if.op_count), 32'd2);

    // Same bits, unsigned then signed, back to back.
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    send(8'hFF, 8'hFF, 1'b1, 16'h0001);
    u_if.in_valid = 1'b0;
    drain();
    check("t2_count", 32'(u_if.op_count), 32'd4);

    // Ten-beat stream at full throughput.
    rdy_low = 0;
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(vt[i].a, vt[i].b, vt[i].s, vt[i].p);
    u_if.in_valid = 1'b0;
    drain();
    check("t3_cycles",   32'(cyc - c0),         32'd12);
    check("t3_rdy_low",  32'(rdy_low),          32'd0);
    check("t3_count",    32'(u_if.op_count),    32'd14);

    // Backpressure: pipeline fills, third beat waits, output frozen.
    u_if.out_ready = 1'b0;
    send(vt[0].a, vt[0].b, vt[0].s, vt[0].p);
    send(vt[1].a, vt[1].b, vt[1].s, vt[1].p);
    u_if.in_valid  = 1'b1;
    u_if.A         = vt[2].a;
    u_if.B         = vt[2].b;
    u_if.in_signed = vt[2].s;
    exp_q.push_back(apx(vt[2].p));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_in_ready", 32'(u_if.in_ready),  32'd0);
      check("t4_valid",    32'(u_if.out_valid), 32'd1);
      check("t4_O_hold",   32'(u_if.O),         32'(apx(vt[0].p)));
    end
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    drain();
    check("t4_count", 32'(u_if.op_count), 32'd17);

    // Reset with two beats in flight.
    u_if.out_ready = 1'b0;
    send(vt[3].a, vt[3].b, vt[3].s, vt[3].p);
    send(vt[4].a, vt[4].b, vt[4].s, vt[4].p);
    u_if.in_valid = 1'b0;
    check("t5_busy_pre", 32'(u_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(u_if.out_valid), 32'd0);
    check("t5_busy",  32'(u_if.busy),      32'd0);
    check("t5_count", 32'(u_if.op_count),  32'd0);
    check("t5_cnt4",  32'(u_if4.op_count), 32'd0);
    exp_q.delete();
    u_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t5_no_stale", 32'(u_if.out_valid), 32'd0);
    end

    // Seventeen ops: 16-bit counter reads 17, 4-bit counter has wrapped to 1.
    for (int i = 0; i < 17; i++) send(vt[i % 10].a, vt[i % 10].b, vt[i % 10].s, vt[i % 10].p);
    u_if.in_valid = 1'b0;
    drain();
    check("t6_count16", 32'(u_if.op_count),  32'd17);
    check("t6_count4",  32'(u_if4.op_count), 32'd1);
    check("t6_idle",    32'(u_if.busy),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
